// File: rtl/dot_product_accumulator.sv
// Streaming dot-product accumulator: sums NUM_TERMS unsigned product terms and presents
// the result with a valid/ready handshake. Optional synchronous abort port via DOTACC_CLEAR_EN.
module dot_product_accumulator #(
  parameter int DATA_W    = 4,
  parameter int NUM_TERMS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
`ifdef DOTACC_CLEAR_EN
  input  logic                                 inClear,
`endif
  input  logic [DATA_W-1:0]                    inProduct,
  input  logic                                 inValid,
  output logic                                 inReady,
  output logic [DATA_W+$clog2(NUM_TERMS)-1:0]  outData,
  output logic                                 outValid,
  input  logic                                 outReady
);

  localparam int ACC_W = DATA_W + $clog2(NUM_TERMS);
  // A single-term build still needs a one-bit counter to hold a legal vector.
  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [ACC_W-1:0]   r_out_data;
  logic [ACC_W-1:0]   w_out_data_nxt;

  logic               w_accept;
  logic               w_last;
  logic               w_handshake;
  logic               w_clear;
  logic [ACC_W-1:0]   w_sum;

`ifdef DOTACC_CLEAR_EN
  assign w_clear = inClear;
`else
  assign w_clear = 1'b0;
`endif

  assign inReady     = (r_state != S_DONE);
  assign outValid    = (r_state == S_DONE);
  // r_out_data is only nonzero while in DONE, so outData reads 0 elsewhere.
  assign outData     = r_out_data;

  assign w_accept    = inValid && inReady;
  assign w_last      = (r_count == LAST);
  assign w_handshake = outValid && outReady;
  assign w_sum       = r_acc + ACC_W'(inProduct);

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_count_nxt    = r_count;
    w_out_data_nxt = r_out_data;

    unique case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = w_sum;
          w_count_nxt = r_count + CNT_W'(1);
          if (w_last) begin
            w_state_nxt    = S_DONE;
            w_out_data_nxt = w_sum;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end
      end
      S_DONE: begin
        if (w_handshake) begin
          w_state_nxt    = S_IDLE;
          w_acc_nxt      = '0;
          w_count_nxt    = '0;
          w_out_data_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_acc_nxt      = '0;
        w_count_nxt    = '0;
        w_out_data_nxt = '0;
      end
    endcase

    // Abort wins over any accept or output handshake in the same cycle.
    if (w_clear) begin
      w_state_nxt    = S_IDLE;
      w_acc_nxt      = '0;
      w_count_nxt    = '0;
      w_out_data_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_count    <= w_count_nxt;
      r_out_data <= w_out_data_nxt;
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: transaction-level model plus literal checks.
// Define DOTACC_CLEAR_EN to also exercise the abort port.
module tb_dot_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inClear = 1'b0;
  logic [3:0] inProduct = '0;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [5:0] outData;
  logic       outValid;
  logic       outReady = 1'b1;

  logic [3:0] in1Product = '0;
  logic       in1Valid = 1'b0;
  logic       in1Ready;
  logic [3:0] out1Data;
  logic       out1Valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dot_product_accumulator #(.DATA_W(4), .NUM_TERMS(4)) u_dut (
    .clk(clk), .rst(rst),
`ifdef DOTACC_CLEAR_EN
    .inClear(inClear),
`endif
    .inProduct(inProduct), .inValid(inValid), .inReady(inReady),
    .outData(outData), .outValid(outValid), .outReady(outReady)
  );

  dot_product_accumulator #(.DATA_W(4), .NUM_TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef DOTACC_CLEAR_EN
    .inClear(1'b0),
`endif
    .inProduct(in1Product), .inValid(in1Valid), .inReady(in1Ready),
    .outData(out1Data), .outValid(out1Valid), .outReady(1'b1)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: collect terms; once NUM_TERMS are in, the sum is on offer until taken.
  int m_terms[$];
  bit m_done = 1'b0;
  int m_result = 0;
  bit m1_done = 1'b0;
  int m1_result = 0;

  always @(posedge clk or posedge rst) begin
    if (rst || inClear) begin
      m_terms.delete();
      m_done   <= 1'b0;
      m_result <= 0;
    end else if (m_done) begin
      if (outReady) begin
        m_done   <= 1'b0;
        m_result <= 0;
      end
    end else if (inValid) begin
      m_terms.push_back(int'(inProduct));
      if (m_terms.size() == 4) begin
        m_done   <= 1'b1;
        m_result <= m_terms.sum();
        m_terms.delete();
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_done   <= 1'b0;
      m1_result <= 0;
    end else if (m1_done) begin
      m1_done   <= 1'b0;
      m1_result <= 0;
    end else if (in1Valid) begin
      m1_done   <= 1'b1;
      m1_result <= int'(in1Product);
    end
  end

  always @(negedge clk) begin
    check("outValid", int'(outValid), int'(m_done));
    check("inReady",  int'(inReady),  int'(!m_done));
    check("outData",  int'(outData),  m_done ? m_result : 0);
    check("out1Valid", int'(out1Valid), int'(m1_done));
    check("in1Ready",  int'(in1Ready),  int'(!m1_done));
    check("out1Data",  int'(out1Data),  m1_done ? m1_result : 0);
  end

  task automatic send(input int t);
    inValid   = 1'b1;
    inProduct = 4'(t);
    @(posedge clk);
    #1;
    inValid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(2);
    check("rst_outValid", int'(outValid), 0);
    check("rst_inReady",  int'(inReady),  1);
    check("rst_outData",  int'(outData),  0);
    rst = 1'b0;
    idle(1);

    // 9,9,9,9 back-to-back
    send(9); send(9); send(9); send(9);
    check("b2b_valid", int'(outValid), 1);
    check("b2b_sum",   int'(outData),  36);
    idle(1);
    check("b2b_idle_valid", int'(outValid), 0);
    check("b2b_idle_ready", int'(inReady),  1);

    // 1,2 bubble bubble 3,4
    send(1); send(2);
    idle(2);
    check("bubble_valid", int'(outValid), 0);
    send(3); send(4);
    check("bubble_sum", int'(outData), 10);
    idle(1);

    // 5,0,0,1 with downstream stalled; pulses of 15 must be ignored
    outReady = 1'b0;
    send(5); send(0); send(0); send(1);
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inProduct = 4'd15;
      @(posedge clk); #1;
      check("stall_sum",   int'(outData), 6);
      check("stall_ready", int'(inReady), 0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    idle(1);
    check("stall_release", int'(outValid), 0);
    send(2); send(2); send(2); send(2);
    check("after_stall_sum", int'(outData), 8);
    idle(1);

    // reset after two terms discards the partial sum
    send(3); send(3);
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(outValid), 0);
    check("midrst_ready", int'(inReady),  1);
    #1;
    rst = 1'b0;
    send(1); send(1); send(1); send(1);
    check("postrst_sum", int'(outData), 4);
    idle(1);

    // single-term instance
    check("n1_pre_valid", int'(out1Valid), 0);
    in1Valid = 1'b1; in1Product = 4'd7;
    @(posedge clk); #1;
    in1Valid = 1'b0;
    check("n1_valid", int'(out1Valid), 1);
    check("n1_sum",   int'(out1Data),  7);
    idle(1);
    check("n1_idle", int'(out1Valid), 0);

`ifdef DOTACC_CLEAR_EN
    send(2); send(2); send(2);
    inClear = 1'b1; inValid = 1'b1; inProduct = 4'd9;
    @(posedge clk); #1;
    inClear = 1'b0; inValid = 1'b0;
    check("clr_valid", int'(outValid), 0);
    check("clr_ready", int'(inReady),  1);
    send(2); send(2); send(2); send(2);
    check("clr_sum", int'(outData), 8);
    idle(1);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
